// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: switch/button inputs, ALU result input and registered ALU-side outputs of the loader.
interface alu_operand_loader_if #(
    parameter int DATA_BUS   = 8,
    parameter int OPCODE_BUS = 6
);
    logic [DATA_BUS-1:0]   i_sw;
    logic                  i_btn_a;
    logic                  i_btn_b;
    logic                  i_btn_op;
    logic [DATA_BUS-1:0]   i_alu_out;
    logic [DATA_BUS-1:0]   o_op1;
    logic [DATA_BUS-1:0]   o_op2;
    logic [OPCODE_BUS-1:0] o_opcode;
    logic [DATA_BUS-1:0]   o_result;
    logic                  o_valid;
    logic [1:0]            o_state;

    modport master (
        output i_sw, i_btn_a, i_btn_b, i_btn_op, i_alu_out,
        input  o_op1, o_op2, o_opcode, o_result, o_valid, o_state
    );

    modport slave (
        input  i_sw, i_btn_a, i_btn_b, i_btn_op, i_alu_out,
        output o_op1, o_op2, o_opcode, o_result, o_valid, o_state
    );
endinterface

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: button-sequenced OP1/OP2/OPCODE loader with result capture for the board ALU.
// Optional per-button debouncer enabled by defining LOADER_DEBOUNCE_EN.
module alu_operand_loader #(
    parameter int DATA_BUS        = 8,
    parameter int OPCODE_BUS      = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    alu_operand_loader_if.slave bus
);
    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [2:0]            w_btn;
    logic [2:0]            w_level;
    logic [2:0]            w_pulse;
    logic [2:0]            r_sync1;
    logic [2:0]            r_sync2;
    logic [2:0]            r_prev;
    state_t                r_state;
    logic [DATA_BUS-1:0]   r_op1;
    logic [DATA_BUS-1:0]   r_op2;
    logic [OPCODE_BUS-1:0] r_opcode;
    logic [DATA_BUS-1:0]   r_result;
    logic                  r_valid;

    assign w_btn   = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};
    assign w_pulse = w_level & ~r_prev;

    // Flops reset high so a button held through reset needs a release before it counts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [2:0]    r_deb;
    logic [CW-1:0] r_cnt [3];

    // Level flips only after the synchronized input has disagreed for DEBOUNCE_CYCLES edges.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (i_rst) begin
                r_deb[i] <= 1'b1;
                r_cnt[i] <= '0;
            end else if (r_sync2[i] == r_deb[i]) begin
                r_cnt[i] <= '0;
            end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_deb[i] <= r_sync2[i];
                r_cnt[i] <= '0;
            end else begin
                r_cnt[i] <= r_cnt[i] + CW'(1);
            end
        end
    end

    assign w_level = r_deb;
`else
    assign w_level = r_sync2;
`endif

    // Only the pulse matching the current state is acted on; all others fall away.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= WAIT_A;
            r_op1    <= '0;
            r_op2    <= '0;
            r_opcode <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                WAIT_A: if (w_pulse[0]) begin
                    r_op1   <= bus.i_sw;
                    r_valid <= 1'b0;
                    r_state <= WAIT_B;
                end
                WAIT_B: if (w_pulse[1]) begin
                    r_op2   <= bus.i_sw;
                    r_state <= WAIT_OP;
                end
                WAIT_OP: if (w_pulse[2]) begin
                    r_opcode <= bus.i_sw[OPCODE_BUS-1:0];
                    r_state  <= CAPTURE;
                end
                CAPTURE: begin
                    r_result <= bus.i_alu_out;
                    r_valid  <= 1'b1;
                    r_state  <= WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_op1    = r_op1;
    assign bus.o_op2    = r_op2;
    assign bus.o_opcode = r_opcode;
    assign bus.o_result = r_result;
    assign bus.o_valid  = r_valid;
    assign bus.o_state  = r_state;
endmodule
